// File: rtl/conv_window_gen.sv
// conv_window_gen
// Streaming 3x3 sliding-window generator. Pixels arrive row-major over a
// valid/ready handshake. Two line buffers hold the two previous image rows.
// Every accepted pixel at (row >= 2, col >= 2) produces one flat 3x3 window
// (valid convolution, no padding) one cycle later.
//
// Ports:
//   clk        clock, rising-edge
//   rst_n      asynchronous reset, active-low
//   in_valid   in_data holds a pixel
//   in_ready   block can accept a pixel this cycle
//   in_data    pixel, row-major, first pixel of a frame is (0,0)
//   out_valid  out_win holds a window
//   out_ready  downstream takes the window this cycle
//   out_win    window, out_win[DATA_W*k +: DATA_W] = w[k], k = 3*wr + wc
//              (w[0] top-left, w[8] bottom-right)
//   out_last   marks the final window of a frame (only while out_valid)
module conv_window_gen #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [9*DATA_W-1:0] out_win,
   output logic                out_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_TWO = CW'(2);
   localparam logic [RW-1:0] ROW_TWO = RW'(2);

   // position counters
   logic [CW-1:0] col_reg, col_next, col_inc;
   logic [RW-1:0] row_reg, row_next;
   logic          col_wrap;

   // handshake
   logic accept;
   logic emit;

   // line buffers (block RAM, registered read)
   logic [DATA_W-1:0] lb1_mem [IMG_W];
   logic [DATA_W-1:0] lb2_mem [IMG_W];
   logic [DATA_W-1:0] lb1_rd_reg, lb2_rd_reg;
   logic [CW-1:0]     rd_addr;

   // window shift register
   logic [DATA_W-1:0]   new_col  [3];
   logic [DATA_W-1:0]   win_reg  [9];
   logic [DATA_W-1:0]   win_next [9];
   logic [9*DATA_W-1:0] win_flat;

   // output stage
   logic                out_valid_reg;
   logic                out_last_reg;
   logic [9*DATA_W-1:0] out_win_reg;

   assign in_ready  = !out_valid_reg || out_ready;
   assign accept    = in_valid && in_ready;
   assign emit      = accept && (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);

   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign out_win   = out_win_reg;

   // ------------------------------------------------------------------
   // counters
   // ------------------------------------------------------------------
   assign col_wrap = (col_reg == COL_MAX);
   assign col_inc  = col_wrap ? '0 : col_reg + CW'(1);

   always_comb begin
      col_next = col_reg;
      row_next = row_reg;
      if (accept) begin
         col_next = col_inc;
         if (col_wrap) begin
            row_next = (row_reg == ROW_MAX) ? '0 : row_reg + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg <= '0;
         row_reg <= '0;
      end else begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   // ------------------------------------------------------------------
   // line buffers
   // The read is prefetched: the address is the column of the *next*
   // pixel, so LBx[c] is already registered when pixel (r,c) arrives.
   // On an accepting edge the write goes to col_reg while the read goes
   // to col_inc, which differ because IMG_W >= 3, so no read-during-write
   // case exists. Contents are never cleared; the row gate keeps stale
   // rows from a previous frame out of any emitted window.
   // ------------------------------------------------------------------
   assign rd_addr = col_next;

   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_mem[col_reg] <= in_data;
         lb2_mem[col_reg] <= lb1_rd_reg;
      end
      lb1_rd_reg <= lb1_mem[rd_addr];
      lb2_rd_reg <= lb2_mem[rd_addr];
   end

   // ------------------------------------------------------------------
   // window shift: columns move left, new column enters at wc = 2
   // ------------------------------------------------------------------
   assign new_col[0] = lb2_rd_reg;   // row r-2 (top)
   assign new_col[1] = lb1_rd_reg;   // row r-1
   assign new_col[2] = in_data;      // row r   (bottom)

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_shift
         assign win_next[3*gi]     = win_reg[3*gi + 1];
         assign win_next[3*gi + 1] = win_reg[3*gi + 2];
         assign win_next[3*gi + 2] = new_col[gi];
      end
      for (genvar gi = 0; gi < 9; gi++) begin : g_pack
         assign win_flat[DATA_W*gi +: DATA_W] = win_next[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 9; k++) begin
            win_reg[k] <= '0;
         end
      end else if (accept) begin
         win_reg <= win_next;
      end
   end

   // ------------------------------------------------------------------
   // output register: load on emit, clear on consume, otherwise hold
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_win_reg   <= '0;
      end else if (emit) begin
         out_valid_reg <= 1'b1;
         out_last_reg  <= (row_reg == ROW_MAX) && col_wrap;
         out_win_reg   <= win_flat;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
// Self-checking bench for conv_window_gen with a 4x4 image of 8-bit pixels.
// A reference model keeps the current frame as a plain pixel array and, on
// every accepted pixel at (r>=2, c>=2), queues the 3x3 neighbourhood it
// expects. Windows taken from the DUT are queued separately and compared
// per scenario.
module tb_conv_window_gen;

   localparam int DW   = 8;
   localparam int IW   = 4;
   localparam int IH   = 4;
   localparam int NPIX = IW * IH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [9*DW-1:0] out_win;
   logic          out_last;

   always #5 clk = ~clk;

   conv_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_win   (out_win),
      .out_last  (out_last)
   );

   typedef struct packed {
      logic [9*DW-1:0] win;
      logic            last;
   } win_t;

   win_t exp_q[$];
   win_t obs_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_pos = 0;
   int   m_img [NPIX];

   logic            s_in_ready, s_out_valid, s_out_last;
   logic [9*DW-1:0] s_out_win;
   logic            last_acc;

   // window of a frame whose pixel value is base + 4*row + col
   function automatic logic [9*DW-1:0] win_of(input int r, input int c, input int base);
      logic [9*DW-1:0] w;
      for (int k = 0; k < 9; k++) begin
         w[DW*k +: DW] = DW'(base + IW*(r - 2 + k/3) + (c - 2 + k%3));
      end
      return w;
   endfunction

   // One clock cycle, entered and left at a falling edge.
   task automatic tick(input logic vld, input logic [DW-1:0] d, input logic rdy);
      win_t e;
      int   r, c;
      in_valid  = vld;
      in_data   = d;
      out_ready = rdy;
      #1;
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_out_win   = out_win;
      s_out_last  = out_last;
      last_acc    = vld && s_in_ready;
      if (s_out_valid && rdy) begin
         e.win  = s_out_win;
         e.last = s_out_last;
         obs_q.push_back(e);
      end
      if (last_acc) begin
         m_img[m_pos] = int'(d);
         r = m_pos / IW;
         c = m_pos % IW;
         if (r >= 2 && c >= 2) begin
            for (int k = 0; k < 9; k++) begin
               e.win[DW*k +: DW] = DW'(m_img[(r - 2 + k/3)*IW + (c - 2 + k%3)]);
            end
            e.last = (m_pos == NPIX - 1);
            exp_q.push_back(e);
         end
         m_pos = (m_pos + 1) % NPIX;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Send npix pixels (value base+index, or random) with random bubbles.
   task automatic stream(input int base, input int npix, input int vld_pct,
                         input int rdy_pct, input bit rnd);
      int            sent = 0;
      int            guard = 0;
      logic [DW-1:0] d;
      logic          v, rd;
      d = rnd ? DW'($urandom) : DW'(base);
      while (sent < npix && guard < 2000) begin
         v  = int'($urandom_range(99)) < vld_pct;
         rd = int'($urandom_range(99)) < rdy_pct;
         tick(v, d, rd);
         if (last_acc) begin
            sent++;
            d = rnd ? DW'($urandom) : DW'(base + sent);
         end
         guard++;
      end
      n_vec++;
      if (sent < npix) begin
         n_err++;
         $display("FAIL stream_timeout: sent %0d pixels, required %0d", sent, npix);
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1);
   endtask

   task automatic clear_q();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(1'b0, '0, 1'b0);
      tick(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      tick(1'b0, '0, 1'b0);
      n_vec++;
      if (s_out_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_out_valid: got %b, required 0", s_out_valid);
      end
      n_vec++;
      if (s_out_last !== 1'b0) begin
         n_err++; $display("FAIL reset_out_last: got %b, required 0", s_out_last);
      end
      n_vec++;
      if (s_out_win !== '0) begin
         n_err++; $display("FAIL reset_out_win: got %h, required 0", s_out_win);
      end
      n_vec++;
      if (s_in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b, required 1", s_in_ready);
      end
      $display("reset: checked outputs after release");
   endtask

   task automatic test_basic();
      clear_q();
      stream(0, NPIX, 100, 100, 1'b0);
      drain(3);
      n_vec++;
      if (obs_q.size() !== 4) begin
         n_err++; $display("FAIL basic_count: got %0d windows, required 4", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         n_vec++;
         if (obs_q[i].win !== win_of(2 + i/2, 2 + i%2, 0) || obs_q[i].last !== (i == 3)) begin
            n_err++;
            $display("FAIL basic_win%0d: got %h last=%b, required %h last=%b",
                     i, obs_q[i].win, obs_q[i].last, win_of(2 + i/2, 2 + i%2, 0), (i == 3));
         end
         $display("basic: window %0d = %h last=%b", i, obs_q[i].win, obs_q[i].last);
      end
   endtask

   task automatic test_gating();
      int   prev = -1;
      logic want;
      clear_q();
      for (int p = 0; p <= NPIX; p++) begin
         tick(p < NPIX, DW'(p), 1'b1);
         if (prev >= 0) begin
            want = (prev / IW >= 2) && (prev % IW >= 2);
            n_vec++;
            if (s_out_valid !== want) begin
               n_err++;
               $display("FAIL gating_px%0d: out_valid got %b, required %b", prev, s_out_valid, want);
            end
         end
         prev = (p < NPIX && last_acc) ? p : -1;
      end
      drain(2);
      $display("gating: per-pixel out_valid checked for one frame");
   endtask

   task automatic test_backpressure();
      clear_q();
      for (int p = 0; p <= 10; p++) tick(1'b1, DW'(p), 1'b1);
      for (int s = 0; s < 5; s++) begin
         tick(1'b1, DW'(11), 1'b0);
         n_vec++;
         if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_out_win !== win_of(2, 2, 0)) begin
            n_err++;
            $display("FAIL stall_cycle%0d: in_ready=%b out_valid=%b win=%h, required 0/1/%h",
                     s, s_in_ready, s_out_valid, s_out_win, win_of(2, 2, 0));
         end
         $display("backpressure: stall cycle %0d win=%h", s, s_out_win);
      end
      tick(1'b1, DW'(11), 1'b1);
      n_vec++;
      if (last_acc !== 1'b1) begin
         n_err++; $display("FAIL stall_release_accept: in_ready got %b, required 1", s_in_ready);
      end
      for (int p = 12; p < NPIX; p++) tick(1'b1, DW'(p), 1'b1);
      drain(3);
      n_vec++;
      if (obs_q.size() !== 4) begin
         n_err++; $display("FAIL stall_count: got %0d windows, required 4", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         n_vec++;
         if (obs_q[i].win !== win_of(2 + i/2, 2 + i%2, 0) || obs_q[i].last !== (i == 3)) begin
            n_err++;
            $display("FAIL stall_win%0d: got %h last=%b, required %h last=%b",
                     i, obs_q[i].win, obs_q[i].last, win_of(2 + i/2, 2 + i%2, 0), (i == 3));
         end
      end
   endtask

   task automatic test_bubbles();
      clear_q();
      stream(0, NPIX, 55, 100, 1'b0);
      drain(3);
      n_vec++;
      if (obs_q.size() !== 4) begin
         n_err++; $display("FAIL bubbles_count: got %0d windows, required 4", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         n_vec++;
         if (obs_q[i].win !== win_of(2 + i/2, 2 + i%2, 0) || obs_q[i].last !== (i == 3)) begin
            n_err++;
            $display("FAIL bubbles_win%0d: got %h last=%b, required %h last=%b",
                     i, obs_q[i].win, obs_q[i].last, win_of(2 + i/2, 2 + i%2, 0), (i == 3));
         end
         $display("bubbles: window %0d = %h", i, obs_q[i].win);
      end
   endtask

   task automatic test_random();
      clear_q();
      for (int f = 0; f < 3; f++) stream(0, NPIX, 70, 60, 1'b1);
      drain(10);
      n_vec++;
      if (obs_q.size() !== 12 || exp_q.size() !== 12) begin
         n_err++;
         $display("FAIL random_count: got %0d windows (model %0d), required 12",
                  obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_vec++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL random_win%0d: got %h last=%b, required %h last=%b",
                     i, obs_q[i].win, obs_q[i].last, exp_q[i].win, exp_q[i].last);
         end
         $display("random: window %0d = %h last=%b", i, obs_q[i].win, obs_q[i].last);
      end
   endtask

   task automatic test_back_to_back();
      int n_last = 0;
      int min_v;
      clear_q();
      stream(0, NPIX, 100, 100, 1'b0);
      stream(100, NPIX, 100, 100, 1'b0);
      drain(3);
      n_vec++;
      if (obs_q.size() !== 8) begin
         n_err++; $display("FAIL b2b_count: got %0d windows, required 8", obs_q.size());
      end
      foreach (obs_q[i]) if (obs_q[i].last) n_last++;
      n_vec++;
      if (n_last !== 2) begin
         n_err++; $display("FAIL b2b_last_count: got %0d, required 2", n_last);
      end
      for (int i = 0; i < obs_q.size() && i < 8; i++) begin
         n_vec++;
         if (obs_q[i].win !== win_of(2 + (i%4)/2, 2 + i%2, (i < 4) ? 0 : 100)) begin
            n_err++;
            $display("FAIL b2b_win%0d: got %h, required %h",
                     i, obs_q[i].win, win_of(2 + (i%4)/2, 2 + i%2, (i < 4) ? 0 : 100));
         end
         if (i >= 4) begin
            min_v = 255;
            for (int k = 0; k < 9; k++) begin
               if (int'(obs_q[i].win[DW*k +: DW]) < min_v) min_v = int'(obs_q[i].win[DW*k +: DW]);
            end
            n_vec++;
            if (min_v < 100) begin
               n_err++; $display("FAIL b2b_stale%0d: smallest pixel %0d, required >= 100", i, min_v);
            end
         end
         $display("b2b: window %0d = %h last=%b", i, obs_q[i].win, obs_q[i].last);
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      stream(0, 10, 100, 100, 1'b0);
      rst_n = 1'b0;
      tick(1'b0, '0, 1'b1);
      m_pos = 0;
      clear_q();
      rst_n = 1'b1;
      tick(1'b0, '0, 1'b0);
      n_vec++;
      if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_state: out_valid=%b in_ready=%b, required 0/1", s_out_valid, s_in_ready);
      end
      stream(0, NPIX, 100, 100, 1'b0);
      drain(3);
      n_vec++;
      if (obs_q.size() !== 4) begin
         n_err++; $display("FAIL midreset_count: got %0d windows, required 4", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 4; i++) begin
         n_vec++;
         if (obs_q[i].win !== win_of(2 + i/2, 2 + i%2, 0) || obs_q[i].last !== (i == 3)) begin
            n_err++;
            $display("FAIL midreset_win%0d: got %h last=%b, required %h last=%b",
                     i, obs_q[i].win, obs_q[i].last, win_of(2 + i/2, 2 + i%2, 0), (i == 3));
         end
         $display("midreset: window %0d = %h", i, obs_q[i].win);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_gating();
      test_backpressure();
      test_bubbles();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 sliding-window generator for the CNN datapath. It accepts a row-major pixel stream over a valid/ready handshake and buffers the two previous image rows in line buffers. For every pixel position where a full 3x3 neighbourhood exists (valid convolution, no padding), it emits that neighbourhood as one flat window word. It sits directly upstream of the convolution PE and feeds it one window per accepted pixel.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  in_data holds a pixel
- in_ready  output  1  block can accept a pixel this cycle
- in_data  input  DATA_W  pixel, row-major order, starting at (row 0, col 0)
- out_valid  output  1  out_win holds a window
- out_ready  input  1  downstream accepts the window this cycle
- out_win  output  9*DATA_W  window; out_win[DATA_W*k +: DATA_W] = w[k], k = 3*wr + wc; w[0] is top-left, w[8] is bottom-right
- out_last  output  1  qualifies the final window of a frame

## Operation
- Accept a pixel on a clock edge where in_valid && in_ready.
- Counters:
  - col runs 0..IMG_W-1; it wraps to 0 and increments row.
  - row runs 0..IMG_H-1; it wraps to 0 after (IMG_H-1, IMG_W-1), which ends the frame.
- Line buffers LB1 and LB2 hold IMG_W entries each. LB1 holds row r-1 and LB2 holds row r-2.
- On accepting pixel p at (r,c):
  - new column = {LB2[c], LB1[c], p} (top to bottom).
  - LB2[c] <= LB1[c]; LB1[c] <= p.
  - The 3x3 window register shifts left by one column and takes the new column at wc=2.
- Window emission:
  - If r >= 2 && c >= 2, load the shifted window into out_win, set out_valid, and set out_last = (r == IMG_H-1 && c == IMG_W-1).
  - Otherwise, no window is produced. out_valid then follows the output handshake rule below.
- Window count per frame is (IMG_W-2)*(IMG_H-2). Row-0/1 pixels and col-0/1 pixels never produce windows.
- Stale line-buffer contents from a previous frame never reach the output, because the row gate blocks them. The line buffers are not cleared between frames.
- Consecutive frames stream back-to-back with no idle cycle required.

## Timing
- Reset (rst_n low, asynchronous):
  - row = 0, col = 0.
  - out_valid = 0, out_last = 0, out_win = 0, window register = 0.
  - in_ready = 1 once reset is released.
  - Line-buffer contents are don't-care.
- in_ready = !out_valid || out_ready. The output is a single register stage, and the input stalls only when a held window is not taken.
- Latency: a window appears (out_valid = 1) on the cycle after the edge that accepted its bottom-right pixel.
- Output handshake:
  - A window is consumed on an edge with out_valid && out_ready.
  - out_valid drops on that edge unless the same edge accepts a pixel that produces a new window.
  - Simultaneous consume and produce gives out_valid = 1 continuously, with out_win updated.
- While out_valid && !out_ready: out_win and out_last are held stable and no pixel is accepted.
- Throughput: 1 pixel/cycle and 1 window/cycle when in_valid and out_ready are held high.
- out_last is valid only while out_valid = 1. It is cleared together with out_valid.
- Reset asserted mid-frame: all counters and outputs return to their reset values immediately. The next accepted pixel is treated as (0,0).
- No protocol error detection: a short or long input frame simply shifts the frame boundary.

## Test plan
All scenarios use IMG_W = 4, IMG_H = 4, DATA_W = 8, with pixel value = 4*row + col (0..15).

- **Basic frame:** stream 16 pixels with in_valid = 1 and out_ready = 1.
  - Exactly 4 windows are produced.
  - The first window appears one cycle after pixel 10 is accepted: w = {0,1,2,4,5,6,8,9,10}.
  - The remaining windows are {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, and {5,6,7,9,10,11,13,14,15}.
  - out_last = 1 only on the last window.
- **Gating:** pixels 0..9 and pixel 12/13 (col < 2) produce no out_valid pulse.
- **Backpressure:** drop out_ready for 5 cycles while window {0,1,2,...,10} is held.
  - in_ready = 0 during the stall, and out_win stays stable.
  - Pixel 11 is accepted only on the edge where out_ready returns.
  - The sequence of windows is unchanged.
- **Input bubbles:** randomly deassert in_valid.
  - Window values and count are identical to the basic frame case.
  - No duplicate windows are produced.
- **Back-to-back frames:** stream two frames, with the second frame's pixels offset by +100.
  - Second-frame windows contain only values >= 100; the first is {100,101,102,104,105,106,108,109,110}.
  - out_last is asserted twice in total.
- **Reset mid-frame:** assert rst_n low after pixel 9.
  - out_valid = 0 and in_ready = 1 after release.
  - A fresh 16-pixel frame yields exactly 4 correct windows.
